// File: rtl/ram_256x8_pkg.sv
// Shared constants for the 256x8 byte-addressed data memory: depth, size codes, FSM encoding.
// Pure declarations; no logic, no latency.
package ram_256x8_pkg;

  localparam int RAM_DEPTH = 256;

  localparam logic [1:0] MS_BYTE = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_WORD = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  // Lane k of an access touches mem[A+k]; byte uses lane 0, halfword lanes 0-1, word all four.
  function automatic logic [3:0] lane_mask(input logic [1:0] ms);
    case (ms)
      MS_BYTE: lane_mask = 4'b0001;
      MS_HALF: lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ram_256x8_if.sv
// MOV/MOC memory bus between the CPU control unit (master) and the data memory (slave).
// MOC stays high while MOV is held, so one MOV assertion is one access.
interface ram_256x8_if;
  logic        MOV;
  logic        ReadWrite;
  logic [2:0]  MS_2_0;
  logic [31:0] DataIn;
  logic [31:0] Address;
  logic        MOC;
  logic [31:0] DataOut;

  modport master (
    output MOV, ReadWrite, MS_2_0, DataIn, Address,
    input  MOC, DataOut
  );

  modport slave (
    input  MOV, ReadWrite, MS_2_0, DataIn, Address,
    output MOC, DataOut
  );
endinterface

// File: rtl/ram_256x8_core.sv
// 256x8 storage with four byte lanes: per-lane write enable and address, combinational read.
// Writes commit on the rising edge; contents have no reset so hierarchical preloads survive.
module ram256x8_core (
  input  logic            clk,
  input  logic [3:0]      we,
  input  logic [3:0][7:0] addr,
  input  logic [3:0][7:0] DataIn,
  output logic [3:0][7:0] rd_dat
);

  reg [7:0] memory [0:255];

  // Lane addresses are always A..A+3 mod 256, hence distinct: no write collisions.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) begin
        memory[addr[k]] <= DataIn[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_dat[k] = memory[addr[k]];
    end
  end

endmodule

// File: rtl/ram_256x8.sv
// Big-endian byte/half/word data memory behind a MOV/MOC handshake; 1-cycle latency,
// MOC held until MOV drops, a held MOV performs exactly one access.
module ram_256x8
  import ram_256x8_pkg::*;
(
  input logic        CLK,
  input logic        RST_N,
  ram_256x8_if.slave bus
);

  logic [0:0]      state_q, state_d;
  logic            moc_q, moc_d;
  logic [31:0]     data_out_q, data_out_d;

  logic [7:0]      base_addr;
  logic [3:0][7:0] lane_addr;
  logic [3:0][7:0] lane_wdat;
  logic [3:0][7:0] lane_rdat;
  logic [3:0]      lane_we;
  logic [31:0]     rd_val;
  logic            sign_ext;
  logic            exec;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^bus.Address[31:8];
  assign base_addr      = bus.Address[7:0];
  assign sign_ext       = bus.MS_2_0[2];

  // Lane 0 always carries the most significant fetched/stored byte (big-endian).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = base_addr + 8'(k);
    end
    lane_wdat = '0;
    rd_val    = '0;
    case (bus.MS_2_0[1:0])
      MS_BYTE: begin
        lane_wdat[0] = bus.DataIn[7:0];
        rd_val       = {{24{sign_ext & lane_rdat[0][7]}}, lane_rdat[0]};
      end
      MS_HALF: begin
        lane_wdat[0] = bus.DataIn[15:8];
        lane_wdat[1] = bus.DataIn[7:0];
        rd_val       = {{16{sign_ext & lane_rdat[0][7]}}, lane_rdat[0], lane_rdat[1]};
      end
      default: begin
        lane_wdat[0] = bus.DataIn[31:24];
        lane_wdat[1] = bus.DataIn[23:16];
        lane_wdat[2] = bus.DataIn[15:8];
        lane_wdat[3] = bus.DataIn[7:0];
        rd_val       = {lane_rdat[0], lane_rdat[1], lane_rdat[2], lane_rdat[3]};
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    moc_d      = moc_q;
    data_out_d = data_out_q;
    exec       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.MOV) begin
          exec    = 1'b1;
          state_d = ST_DONE;
          moc_d   = 1'b1;
          if (bus.ReadWrite) begin
            data_out_d = rd_val;
          end
        end
      end
      default: begin
        if (!bus.MOV) begin
          state_d = ST_IDLE;
          moc_d   = 1'b0;
        end
      end
    endcase
  end

  // Reset must also block the memory write, which lives outside the reset domain.
  assign lane_we = (exec && !bus.ReadWrite && RST_N) ? lane_mask(bus.MS_2_0[1:0]) : 4'b0000;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      moc_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      moc_q      <= moc_d;
      data_out_q <= data_out_d;
    end
  end

  ram256x8_core ram256x8_c (
    .clk    (CLK),
    .we     (lane_we),
    .addr   (lane_addr),
    .DataIn (lane_wdat),
    .rd_dat (lane_rdat)
  );

  assign bus.MOC     = moc_q;
  assign bus.DataOut = data_out_q;

endmodule

// File: tb/tb_ram_256x8.sv
// Random and directed MOV/MOC traffic against an array-based memory model, compared every cycle.
module tb_ram_256x8;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  ram_256x8_if bus ();

  ram_256x8 dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int moc_hi_cnt = 0;

  logic [7:0]  ref_mem [256];
  logic [31:0] ref_dout = '0;
  logic        ref_moc  = 1'b0;
  bit          ref_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: one access per MOV assertion, bytes A..A+n-1 mod 256, big-endian.
  always @(posedge CLK) begin
    int n;
    logic [7:0]  a;
    logic [31:0] v;
    if (!RST_N) begin
      ref_busy = 1'b0;
      ref_moc  = 1'b0;
      ref_dout = '0;
    end else if (bus.MOV && !ref_busy) begin
      n = (bus.MS_2_0[1:0] == 2'b00) ? 1 : (bus.MS_2_0[1:0] == 2'b01) ? 2 : 4;
      a = bus.Address[7:0];
      if (bus.ReadWrite) begin
        v = '0;
        for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[(int'(a) + k) % 256]);
        if (bus.MS_2_0[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        ref_dout = v;
      end else begin
        for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % 256] = 8'(bus.DataIn >> (8*(n-1-k)));
      end
      ref_busy = 1'b1;
      ref_moc  = 1'b1;
    end else if (!bus.MOV && ref_busy) begin
      ref_busy = 1'b0;
      ref_moc  = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("moc", {31'b0, bus.MOC}, {31'b0, ref_moc});
      check("dout", bus.DataOut, ref_dout);
      if (bus.MOC === 1'b1) moc_hi_cnt++;
    end
  end

  // Called at posedge+2; MOV raised here, dropped after `hold` edges, returns one edge later.
  task automatic op(input logic rw, input logic [2:0] ms, input logic [31:0] addr,
                    input logic [31:0] din, input int hold);
    bus.MOV       = 1'b1;
    bus.ReadWrite = rw;
    bus.MS_2_0    = ms;
    bus.Address   = addr;
    bus.DataIn    = din;
    repeat (hold) begin
      @(posedge CLK);
      #2;
      bus.Address = $urandom;
      bus.DataIn  = $urandom;
      bus.MS_2_0  = 3'($urandom_range(7));
    end
    bus.MOV = 1'b0;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    logic [7:0] mem_act;
    bus.MOV = 1'b0; bus.ReadWrite = 1'b1; bus.MS_2_0 = 3'b000;
    bus.DataIn = '0; bus.Address = '0;
    for (int i = 0; i < 256; i++) begin
      dut.ram256x8_c.memory[i] = 8'(i);
      ref_mem[i] = 8'(i);
    end
    repeat (3) @(posedge CLK);
    #2;
    RST_N  = 1'b1;
    chk_en = 1'b1;
    check("rst_moc", {31'b0, bus.MOC}, 32'h0);
    check("rst_dout", bus.DataOut, 32'h0);

    op(1'b1, 3'b000, 32'd1, '0, 1);
    check("rd_b1", bus.DataOut, 32'h0000_0001);
    op(1'b1, 3'b001, 32'd14, '0, 1);
    check("rd_h14", bus.DataOut, 32'h0000_0E0F);
    op(1'b1, 3'b010, 32'hFFFF_FF12, '0, 1);
    check("rd_w18_hiaddr", bus.DataOut, 32'h1213_1415);
    check("model_w18", ref_dout, 32'h1213_1415);

    op(1'b0, 3'b000, 32'd1, 32'hFFFF_FFC3, 1);
    check("wr_keeps_dout", bus.DataOut, 32'h1213_1415);
    op(1'b1, 3'b000, 32'd1, '0, 1);
    check("rd_b1_u", bus.DataOut, 32'h0000_00C3);
    op(1'b1, 3'b100, 32'd1, '0, 1);
    check("rd_b1_s", bus.DataOut, 32'hFFFF_FFC3);
    check("model_b1_s", ref_dout, 32'hFFFF_FFC3);

    op(1'b0, 3'b001, 32'd10, 32'h0000_FFFF, 1);
    op(1'b1, 3'b001, 32'd10, '0, 1);
    check("rd_h10_u", bus.DataOut, 32'h0000_FFFF);
    op(1'b1, 3'b101, 32'd10, '0, 1);
    check("rd_h10_s", bus.DataOut, 32'hFFFF_FFFF);

    op(1'b0, 3'b010, 32'd13, 32'hC000_0001, 1);
    mem_act = dut.ram256x8_c.memory[13];
    check("mem13", {24'b0, mem_act}, 32'hC0);
    mem_act = dut.ram256x8_c.memory[16];
    check("mem16", {24'b0, mem_act}, 32'h01);
    op(1'b1, 3'b110, 32'd14, '0, 1);
    check("rd_w14", bus.DataOut, 32'h0000_0111);
    check("model_w14", ref_dout, 32'h0000_0111);

    op(1'b0, 3'b011, 32'd254, 32'hAABB_CCDD, 1);
    mem_act = dut.ram256x8_c.memory[255];
    check("mem255", {24'b0, mem_act}, 32'hBB);
    mem_act = dut.ram256x8_c.memory[0];
    check("mem0_wrap", {24'b0, mem_act}, 32'hCC);
    mem_act = dut.ram256x8_c.memory[1];
    check("mem1_wrap", {24'b0, mem_act}, 32'hDD);
    op(1'b1, 3'b010, 32'd254, '0, 1);
    check("rd_w254", bus.DataOut, 32'hAABB_CCDD);

    moc_hi_cnt = 0;
    op(1'b0, 3'b000, 32'd0, 32'h0000_0055, 3);
    check("hold_moc_cycles", 32'(moc_hi_cnt), 32'd3);
    check("hold_moc_low", {31'b0, bus.MOC}, 32'h0);
    mem_act = dut.ram256x8_c.memory[0];
    check("hold_mem0", {24'b0, mem_act}, 32'h55);

    RST_N = 1'b0;
    bus.MOV = 1'b1; bus.ReadWrite = 1'b0; bus.MS_2_0 = 3'b000;
    bus.Address = 32'd5; bus.DataIn = 32'h99;
    @(posedge CLK);
    #2;
    check("rstmov_moc", {31'b0, bus.MOC}, 32'h0);
    check("rstmov_dout", bus.DataOut, 32'h0);
    mem_act = dut.ram256x8_c.memory[5];
    check("rstmov_mem5", {24'b0, mem_act}, 32'h05);
    bus.MOV = 1'b0;
    RST_N = 1'b1;
    @(posedge CLK);
    #2;

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(19) == 0) begin
        RST_N = 1'b0;
        bus.MOV = 1'b1;
        bus.ReadWrite = 1'($urandom_range(1));
        bus.Address = $urandom;
        bus.DataIn = $urandom;
        @(posedge CLK);
        #2;
        bus.MOV = 1'b0;
        RST_N = 1'b1;
      end
      op(1'($urandom_range(1)), 3'($urandom_range(7)), $urandom, $urandom,
         int'($urandom_range(1, 3)));
      repeat ($urandom_range(2)) begin
        @(posedge CLK);
        #2;
      end
    end

    for (int i = 0; i < 256; i++) begin
      mem_act = dut.ram256x8_c.memory[i];
      check("mem_final", {24'b0, mem_act}, {24'b0, ref_mem[i]});
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
